branch_predictor_btb: RTL
=========================

BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 SHALL have parameter PC_W, default 8: PC / branch-target width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16: BTB depth; power of two; IDX_W = log2(ENTRIES); PC_W >= IDX_W+3 required.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port lookup_pc, input, PC_W: IF-stage PC.
REQ-007 SHALL have port pred_hit, output, 1: valid entry with matching tag at lookup_pc.
REQ-008 SHALL have port pred_taken, output, 1: predict taken.
REQ-009 SHALL have port pred_target, output, PC_W: predicted next PC.
REQ-010 SHALL have port upd_valid, input, 1: resolved branch present in EX/MEM this cycle.
REQ-011 SHALL have port upd_pc, input, PC_W: PC of the resolved branch.
REQ-012 SHALL have port upd_taken, input, 1: actual outcome.
REQ-013 SHALL have port upd_target, input, PC_W: actual taken target.
REQ-014 SHALL have port upd_pred_taken, input, 1: prediction carried down the pipe with the branch.
REQ-015 SHALL have port upd_pred_target, input, PC_W: predicted target carried down the pipe with the branch.
REQ-016 SHALL have port mispredict, output, 1: registered flush request.
REQ-017 SHALL have port redirect_pc, output, PC_W: registered corrected PC.

Function
REQ-018 SHALL split the PC as follows: index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-019 SHALL make lookup purely combinational, giving a 0-cycle result in the same cycle as instruction fetch.
REQ-020 SHALL drive pred_hit = valid[idx] && tag match; pred_taken = pred_hit && ctr[idx][1].
REQ-021 SHALL drive pred_target = stored target when pred_taken, else lookup_pc+4, truncated to PC_W (0xFC+4 -> 0x00).
REQ-022 SHALL keep a 2-bit saturating counter per entry: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-023 SHALL, on upd_valid with tag hit, increment the counter if taken (saturating at 11), else decrement it (saturating at 00).
REQ-024 SHALL, on upd_valid with tag hit and taken, overwrite the stored target with upd_target.
REQ-025 SHALL, on upd_valid with a tag miss and taken, allocate the entry: valid=1, tag, target, ctr=10, replacing any aliased entry.
REQ-026 SHALL, on upd_valid with a tag miss and not taken, leave the table unchanged.
REQ-027 SHALL, when update and lookup hit the same index in one cycle, return the pre-update state to lookup, with no bypass.
REQ-028 SHALL register mispredict one cycle after upd_valid, set to (upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target); mispredict SHALL be 0 in cycles without upd_valid.
REQ-029 SHALL register redirect_pc with mispredict, set to upd_taken ? upd_target : upd_pc+4 (mod 2^PC_W); it SHALL hold its value when upd_valid=0.

Reset
REQ-030 SHALL, on rst_n=0 at a rising clk edge, clear all valid bits, set all counters to 01, and set mispredict=0, redirect_pc=0 and all stats counters to 0.
REQ-031 SHALL ignore upd_valid in any cycle where rst_n=0; no allocation or counter change.
REQ-032 SHALL keep tag/target storage uncleared on reset, since valid=0 masks it.

Configuration
REQ-033 SHALL support macro BP_STATS_EN; when it is defined, the block SHALL add output ports stat_updates (32) and stat_mispredicts (32).
REQ-034 SHALL, with BP_STATS_EN defined, count upd_valid cycles in stat_updates and asserted-mispredict cycles in stat_mispredicts; each counter SHALL saturate at 0xFFFFFFFF.
REQ-035 SHALL, without BP_STATS_EN, omit the ports and counters entirely, with behaviour otherwise identical.

Structure
REQ-036 SHALL provide package bp_pkg holding: counter encodings, PC_STEP=4 constant, and the saturating next-counter function.
REQ-037 SHALL use one sub-module, bp_sat_ctr: combinational 2-bit saturating update, instantiated once on the update path.

Verification (PC_W=8, ENTRIES=16)
REQ-038 SHALL verify the post-reset miss: reset, lookup_pc=0x10 -> pred_hit=0, pred_taken=0, pred_target=0x14.
REQ-039 SHALL verify allocation: update pc=0x10, taken, target=0x40, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x40; then lookup 0x10 -> hit, taken, target 0x40.
REQ-040 SHALL verify aliasing: after REQ-039, update pc=0x50 (same index 4, tag 1), taken, target 0x80 -> lookup 0x10 gives pred_hit=0; lookup 0x50 gives target 0x80.
REQ-041 SHALL verify counter saturation: entry at ctr 10, then 2 taken -> 11 (saturates), then 2 not-taken -> 01 with pred_taken=0, then 2 more not-taken -> 00 (saturates).
REQ-042 SHALL verify wrap: lookup 0xFC on a miss -> pred_target=0x00; not-taken update at 0xFC with upd_pred_taken=0 -> mispredict=0, redirect_pc=0x00.
REQ-043 SHALL verify reset mid-operation: rst_n=0 in the same cycle as a taken upd_valid at 0x20 -> next cycle mispredict=0 and lookup 0x20 misses; with BP_STATS_EN, both stats read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// the sequential PC step and the saturating counter update function.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam int unsigned PC_STEP = 4;

  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational 2-bit saturating counter step used on the BTB update path.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  assign ctr_o = sat_ctr_next(ctr_i, taken_i);

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters, combinational lookup and registered
// mispredict/redirect. Define BP_STATS_EN to add update/mispredict counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [PC_W-1:0]    tgt_mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic [1:0]       ctr_next;

  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirect_q, redirect_d;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];

  // Lookup sees the table as it was before this cycle's update.
  assign pred_hit    = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? tgt_mem[lk_idx] : lookup_pc + PC_W'(PC_STEP);

  assign up_hit = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (ctr_q[up_idx]),
    .taken_i (upd_taken),
    .ctr_o   (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

  // Tag/target storage carries no reset; valid_q masks stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && upd_valid && upd_taken) begin
      tag_mem[up_idx] <= up_tag;
      tgt_mem[up_idx] <= upd_target;
    end
  end

  always_comb begin
    mispredict_d = 1'b0;
    redirect_d   = redirect_q;
    if (upd_valid) begin
      mispredict_d = (upd_taken != upd_pred_taken) ||
                     (upd_taken && (upd_pred_target != upd_target));
      redirect_d   = upd_taken ? upd_target : upd_pc + PC_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_upd_q, stat_misp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_upd_q  <= '0;
      stat_misp_q <= '0;
    end else begin
      if (upd_valid && (stat_upd_q != '1))     stat_upd_q  <= stat_upd_q + 32'd1;
      if (mispredict_q && (stat_misp_q != '1)) stat_misp_q <= stat_misp_q + 32'd1;
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_misp_q;
`endif

endmodule
